mac_job_sequencer: RTL and testbench

//  Sequences one dot-product job through the MAC datapath and its output data pipeline.
//  On a start handshake it issues len operand addresses with a MAC enable strobe, and clears the accumulator on the first issue.
//  It tracks the fixed output pipeline latency, pulses a capture enable when the final result emerges, and holds a result-valid handshake until it is consumed.

---
 rtl/mac_job_sequencer.sv | 170 +++++++++++++++++
 tb/tb_mac_job_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mac_job_sequencer.sv
// Sequencer for one dot-product job: issues operand addresses to the MAC, waits out the output
// pipeline latency, strobes the result capture and holds a valid/ready handshake. Optional job
// cycle counter enabled by defining MAC_SEQ_PERF_CNT_EN.
module mac_job_sequencer #(
  parameter int AddrWidth  = 8,
  parameter int LenWidth   = 9,
  parameter int PipeStages = 5
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 start,
  input  logic [LenWidth-1:0]  len,
  input  logic [AddrWidth-1:0] base_addr,
  output logic                 busy,
  output logic [AddrWidth-1:0] rd_addr,
  output logic                 mac_en,
  output logic                 acc_clr,
  output logic                 cap_en,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef MAC_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]          job_cycles
`endif
);

  localparam int DrainWidth = (PipeStages > 1) ? $clog2(PipeStages) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            state_q,     state_d;
  logic [LenWidth-1:0]   idx_q,       idx_d;
  logic [LenWidth-1:0]   len_q,       len_d;
  logic [AddrWidth-1:0]  base_q,      base_d;
  logic [DrainWidth-1:0] drain_q,     drain_d;
  logic                  busy_q,      busy_d;
  logic [AddrWidth-1:0]  rd_addr_q,   rd_addr_d;
  logic                  mac_en_q,    mac_en_d;
  logic                  acc_clr_q,   acc_clr_d;
  logic                  cap_en_q,    cap_en_d;
  logic                  out_valid_q, out_valid_d;
  logic                  accept;

  assign accept = (state_q == ST_IDLE) && start && (len != '0);

  // Outputs are registered, so each branch computes what the next cycle must show;
  // idx counts issues already scheduled, which is the offset of the next operand.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    base_d      = base_q;
    drain_d     = drain_q;
    busy_d      = busy_q;
    rd_addr_d   = '0;
    mac_en_d    = 1'b0;
    acc_clr_d   = 1'b0;
    cap_en_d    = 1'b0;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_ISSUE;
          len_d     = len;
          base_d    = base_addr;
          idx_d     = LenWidth'(1);
          busy_d    = 1'b1;
          mac_en_d  = 1'b1;
          rd_addr_d = base_addr;
          acc_clr_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (idx_q == len_q) begin
          state_d  = ST_DRAIN;
          drain_d  = DrainWidth'(PipeStages - 1);
          cap_en_d = (PipeStages == 1);
        end else begin
          mac_en_d  = 1'b1;
          rd_addr_d = base_q + AddrWidth'(idx_q);
          idx_d     = idx_q + LenWidth'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end else begin
          drain_d  = drain_q - DrainWidth'(1);
          cap_en_d = (drain_q == DrainWidth'(1));
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          idx_d       = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      base_q      <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      rd_addr_q   <= '0;
      mac_en_q    <= 1'b0;
      acc_clr_q   <= 1'b0;
      cap_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      base_q      <= base_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      rd_addr_q   <= rd_addr_d;
      mac_en_q    <= mac_en_d;
      acc_clr_q   <= acc_clr_d;
      cap_en_q    <= cap_en_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = busy_q;
  assign rd_addr   = rd_addr_q;
  assign mac_en    = mac_en_q;
  assign acc_clr   = acc_clr_q;
  assign cap_en    = cap_en_q;
  assign out_valid = out_valid_q;

`ifdef MAC_SEQ_PERF_CNT_EN
  logic [15:0] job_cycles_q, job_cycles_d;

  // Counts the ISSUE and DRAIN cycles, i.e. acceptance through the cap_en cycle.
  always_comb begin
    job_cycles_d = job_cycles_q;
    if (accept) begin
      job_cycles_d = '0;
    end else if (((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) && (job_cycles_q != 16'hFFFF)) begin
      job_cycles_d = job_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      job_cycles_q <= '0;
    end else begin
      job_cycles_q <= job_cycles_d;
    end
  end

  assign job_cycles = job_cycles_q;
`endif

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Self-checking bench for mac_job_sequencer: directed scenarios followed by random jobs, all
// compared each cycle against a job-timeline model (offset since acceptance).
module tb_mac_job_sequencer;
  localparam int AW = 8;
  localparam int LW = 9;
  localparam int P  = 5;

  logic          clk = 1'b0;
  logic          aclr = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic [AW-1:0] base_addr = '0;
  logic          out_ready = 1'b0;
  logic          busy, mac_en, acc_clr, cap_en, out_valid;
  logic [AW-1:0] rd_addr;
`ifdef MAC_SEQ_PERF_CNT_EN
  logic [15:0]   job_cycles;
`endif

  always #5 clk = ~clk;

  mac_job_sequencer #(.AddrWidth(AW), .LenWidth(LW), .PipeStages(P)) dut (
    .clk       (clk),
    .aclr      (aclr),
    .start     (start),
    .len       (len),
    .base_addr (base_addr),
    .busy      (busy),
    .rd_addr   (rd_addr),
    .mac_en    (mac_en),
    .acc_clr   (acc_clr),
    .cap_en    (cap_en),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MAC_SEQ_PERF_CNT_EN
    ,
    .job_cycles(job_cycles)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: a job is described by its latched len/base and the offset t of the current cycle
  // from the acceptance cycle (t=1 is the first cycle after acceptance).
  bit m_active = 1'b0;
  int m_t      = 0;
  int m_len    = 0;
  int m_base   = 0;
  int m_cycles = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit a, input bit s, input int l, input int b, input bit r);
    bit prev_valid;
    bit e_mac;
    aclr      = a;
    start     = s;
    len       = l[LW-1:0];
    base_addr = b[AW-1:0];
    out_ready = r;
    prev_valid = m_active && (m_t > m_len + P);
    @(posedge clk);
    cyc++;
    if (a) begin
      m_active = 1'b0;
      m_cycles = 0;
    end else if (!m_active) begin
      if (s && (l != 0)) begin
        m_active = 1'b1;
        m_t      = 1;
        m_len    = l;
        m_base   = b;
      end
    end else if (prev_valid && r) begin
      m_active = 1'b0;
    end else begin
      m_t++;
    end
    if (m_active) m_cycles = (m_t - 1 < m_len + P) ? m_t - 1 : m_len + P;
    e_mac = m_active && (m_t <= m_len);
    #1;
    check("busy",      32'(busy),      32'(m_active));
    check("mac_en",    32'(mac_en),    32'(e_mac));
    check("rd_addr",   32'(rd_addr),   e_mac ? 32'((m_base + m_t - 1) % (1 << AW)) : 32'd0);
    check("acc_clr",   32'(acc_clr),   32'(m_active && (m_t == 1)));
    check("cap_en",    32'(cap_en),    32'(m_active && (m_t == m_len + P)));
    check("out_valid", 32'(out_valid), 32'(m_active && (m_t > m_len + P)));
`ifdef MAC_SEQ_PERF_CNT_EN
    check("job_cycles", 32'(job_cycles), 32'(m_cycles));
`endif
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, r);
  endtask

  initial begin
    // Reset
    step(1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 4, 8'h10, 1'b1);
    idle(2, 1'b1);

    // Basic job and address wrap
    step(1'b0, 1'b1, 4, 8'h10, 1'b1);
    idle(12, 1'b1);
    step(1'b0, 1'b1, 4, 8'hFE, 1'b1);
    idle(12, 1'b1);

    // len=0 is ignored, then a single-op job
    step(1'b0, 1'b1, 0, 8'h33, 1'b1);
    idle(2, 1'b1);
    step(1'b0, 1'b1, 1, 8'h44, 1'b1);
    idle(8, 1'b1);

    // Consumer stalls in DONE while start is pulsed; len/base changes mid-job have no effect
    step(1'b0, 1'b1, 3, 8'h20, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, (i % 3) == 0, 5 + i, 8'h80 + i, 1'b0);
    idle(3, 1'b1);

    // Mid-job reset, then a fresh job
    step(1'b0, 1'b1, 8, 8'h50, 1'b1);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    step(1'b1, 1'b0, 0, 0, 1'b1);
    idle(16, 1'b1);
    step(1'b0, 1'b1, 2, 8'hF0, 1'b1);
    idle(10, 1'b1);

    // Random jobs, stalls and occasional resets
    for (int i = 0; i < 3000; i++) begin
      int rl;
      rl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(1, 12);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, rl,
           $urandom_range(0, 255), $urandom_range(0, 1) == 1);
    end
    idle(30, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
